v2f_lane_unpacker: RTL
======================

// Module: v2f_lane_unpacker
// PURPOSE
//  Reassembles one wide value from a burst of 32-bit lanes (one Factorio signal word per tick).
//  It is the receive end of the lane-splitting scheme that the 32-bit combinator mapping
//  depends on. Values wider than a combinator word cross the circuit network as sequential
//  lanes, LSB lane first; this block rebuilds them for wide-datapath logic.
//  Valid/ready on both sides; one burst per output word.
// PARAMETERS
//  OUT_WIDTH   64  width of reassembled word; 33..256
//  OUT_SIGNED  0   1: sign-extend short bursts from bit 31 of last lane; 0: zero-extend
//  LANES       derived = (OUT_WIDTH+31)/32, localparam, not overridable
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_data    in   32         lane word; lane k carries bits [32k+31:32k]
//  in_valid   in   1          lane present
//  in_last    in   1          final lane of burst; qualified by in_valid
//  in_ready   out  1          lane accepted when in_valid && in_ready
//  out_data   out  OUT_WIDTH  reassembled word
//  out_valid  out  1          out_data/out_short/out_long/out_lanes valid
//  out_ready  in   1          consumer accepts when out_valid && out_ready
//  out_short  out  1          burst had fewer than LANES lanes (extended per OUT_SIGNED)
//  out_long   out  1          burst had more than LANES lanes (excess discarded)
//  out_lanes  out  9          lanes received, saturating at 511
// BEHAVIOUR
//  Reset: state=COLLECT, lane index 0, accumulator 0, out_data 0, out_valid 0,
//   out_short/out_long 0, out_lanes 0, in_ready 1. Takes effect mid-burst and mid-hold;
//   a partial burst or unconsumed word is discarded.
//  States:
//   COLLECT: in_ready=1. Each accepted lane writes accumulator slice idx; idx++.
//    If idx>=LANES, drop the data, set long flag, still count.
//    Accept with in_last -> HOLD next cycle.
//   HOLD: in_ready=0. out_valid=1; outputs stable until out_ready.
//    Fire -> COLLECT next cycle, idx/flags/accumulator cleared.
//  Latency: out_valid rises the cycle after the last lane is accepted.
//   Min period per word = lanes+1 cycles; one bubble after each fire, no same-cycle fire/accept.
//  Output word:
//   Short burst of n lanes: bits >= 32n = {replicate bit 32n-1 if OUT_SIGNED else 0}.
//   OUT_WIDTH not a multiple of 32: top lane truncated, its unused upper bits ignored
//    (no long flag).
//   Exact burst: out_short=out_long=0.
//  in_data/in_last are ignored when in_valid=0; in_valid is ignored in HOLD (no accept).
//  Lane counter saturates at 511. out_long is set for any count > LANES.
//  Single-lane burst with in_last on the first lane is legal: short when LANES>1.
// TESTING
//  T1 OUT_WIDTH=64: lanes 0xDEADBEEF, 0x12345678(last) -> out_data=0x12345678DEADBEEF,
//     short=0, long=0, lanes=2, out_valid on cycle after last.
//  T2 OUT_SIGNED=1, 64: one lane 0x80000001(last) -> 0xFFFFFFFF80000001, short=1;
//     repeat with OUT_SIGNED=0 -> 0x0000000080000001.
//  T3 64: lanes 1,2,3(last) -> out_data=0x0000000200000001, long=1, lanes=3.
//  T4 backpressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, following lane
//     not accepted; out_ready=1 -> fire, in_ready=1 next cycle, next burst assembles correctly.
//  T5 rst=1 after lane 0 of a 2-lane burst -> next cycle all outputs at reset values;
//     new burst 0xA,0xB(last) -> 0x0000000B0000000A.
//  T6 OUT_WIDTH=40: lanes 0xFFFFFFFF, 0xFFFFFFFF(last) -> out_data=0xFFFFFFFFFF, long=0;
//     random valid gaps give the same result.

Source files
------------

// File: rtl/v2f_lane_unpacker_if.sv
// Lane-in / wide-word-out handshake bundle for the lane unpacker.
// The unpacker takes the slave side; whatever feeds lanes and drains words takes the master side.
interface v2f_lane_unpacker_if #(
    parameter int OUT_WIDTH = 64
);
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_short;
    logic                 out_long;
    logic [8:0]           out_lanes;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_short, out_long, out_lanes
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_short, out_long, out_lanes
    );
endinterface

// File: rtl/v2f_lane_unpacker.sv
// Rebuilds one OUT_WIDTH-bit word from a burst of 32-bit lanes, LSB lane first,
// then holds it until the consumer takes it.
module v2f_lane_unpacker #(
    parameter int OUT_WIDTH  = 64,
    parameter bit OUT_SIGNED = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    v2f_lane_unpacker_if.slave   io_bus
);
    localparam int         LANES   = (OUT_WIDTH + 31) / 32;
    localparam int         ACC_W   = LANES * 32;
    localparam logic [8:0] LANES_9 = 9'(LANES);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_accNext;
    logic [ACC_W-1:0]     w_extWord;
    logic [8:0]           r_cnt;
    logic [8:0]           w_cntNext;
    logic [OUT_WIDTH-1:0] r_outData;
    logic                 r_outShort;
    logic                 r_outLong;
    logic [8:0]           r_outLanes;
    logic                 w_inReady;
    logic                 w_outValid;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_fillBit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        case (r_state)
            COLLECT: begin
                w_inReady = 1'b1;
                if (io_bus.in_valid && io_bus.in_last) begin
                    w_stateNext = HOLD;
                end
            end
            HOLD: begin
                w_outValid = 1'b1;
                if (io_bus.out_ready) begin
                    w_stateNext = COLLECT;
                end
            end
            default: w_stateNext = COLLECT;
        endcase
    end

    assign w_accept = w_inReady && io_bus.in_valid;
    assign w_fire   = w_outValid && io_bus.out_ready;

    // Lanes beyond the last slice are counted but their data never lands anywhere.
    always_comb begin
        w_accNext = r_acc;
        for (int k = 0; k < LANES; k++) begin
            if (r_cnt == 9'(k)) begin
                w_accNext[k*32 +: 32] = io_bus.in_data;
            end
        end
        w_cntNext = (r_cnt == 9'd511) ? r_cnt : r_cnt + 9'd1;
    end

    // For a short burst of n lanes, every slice from n upward is filled from bit 32n-1.
    always_comb begin
        w_fillBit = 1'b0;
        for (int k = 1; k < LANES; k++) begin
            if (w_cntNext == 9'(k)) begin
                w_fillBit = OUT_SIGNED && w_accNext[k*32-1];
            end
        end
        w_extWord = w_accNext;
        for (int k = 1; k < LANES; k++) begin
            if (w_cntNext <= 9'(k)) begin
                w_extWord[k*32 +: 32] = {32{w_fillBit}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_outData  <= '0;
            r_outShort <= 1'b0;
            r_outLong  <= 1'b0;
            r_outLanes <= '0;
        end else if (w_accept) begin
            r_acc <= w_accNext;
            r_cnt <= w_cntNext;
            if (io_bus.in_last) begin
                r_outData  <= w_extWord[OUT_WIDTH-1:0];
                r_outShort <= (w_cntNext < LANES_9);
                r_outLong  <= (w_cntNext > LANES_9);
                r_outLanes <= w_cntNext;
            end
        end else if (w_fire) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_outData  <= '0;
            r_outShort <= 1'b0;
            r_outLong  <= 1'b0;
            r_outLanes <= '0;
        end
    end

    assign io_bus.in_ready  = w_inReady;
    assign io_bus.out_valid = w_outValid;
    assign io_bus.out_data  = r_outData;
    assign io_bus.out_short = r_outShort;
    assign io_bus.out_long  = r_outLong;
    assign io_bus.out_lanes = r_outLanes;
endmodule
